pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. Generates per-stage stall/bubble strobes for the F, D, E, M and W pipeline registers: load/use and `ret` hazards, branch mispredicts, exception freeze. Owns a run-state machine that halts on a faulting writeback and supports an external drain/pause/resume request. Optionally keeps cycle and retired-instruction counters.

## Interface

- No parameters. Codes come from `define.v`: `SAOK`, `SHLT`, `SADR`, `SINS`, `INOP`, `IMRMOVQ`, `IPOPQ`, `IRET`, `IJXX`, `RNONE`.

Ports:

- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `D_icode_i` in 4: icode in the D register.
- `d_srcA_i`, `d_srcB_i` in 4 each: decode source registers.
- `E_icode_i` in 4, `E_dstM_i` in 4: E register icode and load destination.
- `e_Cnd_i` in 1: branch condition computed in E.
- `M_icode_i` in 4: icode in the M register.
- `m_stat_i` in 3: status produced by the memory stage.
- `W_icode_i` in 4, `W_stat_i` in 3: W register icode and status.
- `halt_req_i` in 1: request to drain and pause. Level; sampled each cycle in RUN.
- `resume_i` in 1: leave PAUSED.
- `F_stall_o`, `D_stall_o`, `D_bubble_o`, `E_bubble_o`, `M_bubble_o`, `W_stall_o` out 1 each: strobes to the pipeline registers.
- `state_o` out 2: 0 RUN, 1 DRAIN, 2 PAUSED, 3 HALTED.
- `halt_stat_o` out 3: status captured on entry to HALTED.
- `cycle_cnt_o`, `retire_cnt_o` out 64 each: performance counters.

## Operation

Hazard terms (combinational):

- lu = (`E_icode` is `IMRMOVQ` or `IPOPQ`) and `E_dstM` != `RNONE` and `E_dstM` equals `d_srcA` or `d_srcB`.
- rt = `IRET` is in any of D, E or M.
- mp = `E_icode` is `IJXX` and `e_Cnd` = 0.
- exc(s) = s is `SADR`, `SINS` or `SHLT`.

Strobes in RUN:

- `F_stall` = lu | rt.
- `D_stall` = lu.
- `D_bubble` = mp | (rt & !lu).
- `E_bubble` = mp | lu.
- `M_bubble` = exc(`m_stat`) | exc(`W_stat`).
- `W_stall` = exc(`W_stat`).

Strobes in other states:

- DRAIN: `F_stall`=`D_stall`=`E_bubble`=1, `D_bubble`=0. `M_bubble`/`W_stall` as in RUN.
- PAUSED: `F_stall`=`D_stall`=`E_bubble`=`M_bubble`=`W_stall`=1, `D_bubble`=0.
- HALTED: same as PAUSED.

State transitions (registered), highest priority first:

- Any state except HALTED, exc(`W_stat`) → HALTED; `halt_stat_o` <= `W_stat`.
- RUN, `halt_req` & !lu & !rt & !mp → DRAIN. A request with a hazard present is deferred; it is not lost while held high.
- DRAIN, `E_icode`=`M_icode`=`W_icode`=`INOP` → PAUSED.
- PAUSED, `resume` → RUN.
- HALTED is left only by reset. `resume` and `halt_req` are ignored there.

The instruction held in D during DRAIN/PAUSED is preserved; after resume it proceeds with no instruction lost or duplicated.

## Timing

- Strobes are combinational from inputs and the current state; pipeline registers act on them at the same edge.
- State transition latency: one edge.
- Drain completes at most 3 cycles after entering DRAIN.
- `W_stall` asserts in the same cycle the faulting status reaches W; HALTED is visible the next cycle.
- Reset values: `state_o`=0 (RUN), `halt_stat_o`=`SAOK`, both counters 0.
- Strobes after reset: all 0, given `SAOK`/`INOP` inputs.
- Reset asserted mid-DRAIN or in HALTED forces RUN immediately (asynchronous).

## Configuration

- `PIPE_CTRL_PERF_EN` defined:
  - `cycle_cnt_o` increments every cycle in RUN or DRAIN.
  - `retire_cnt_o` increments when `W_icode` != `INOP`, `W_stat` = `SAOK` and the state is not PAUSED/HALTED.
  - Both wrap modulo 2^64.
- Undefined: both counters are tied to 0 and their registers are not built.

## Test plan

- Load/use: `E_icode`=`IMRMOVQ`, `E_dstM`=3, `d_srcA`=3 → `F_stall`=`D_stall`=`E_bubble`=1, `D_bubble`=0 for one cycle.
- Mispredict plus `ret`: `E_icode`=`IJXX`, `e_Cnd`=0, `D_icode`=`IRET` → `D_bubble`=`E_bubble`=1, `F_stall`=1.
- Exception: `W_stat`=`SADR` → `W_stall`=`M_bubble`=1 that cycle; next cycle `state_o`=3, `halt_stat_o`=`SADR`; `resume` pulse leaves state at 3.
- Drain: `halt_req` with no hazard, E/M/W go `INOP` over 3 cycles → state sequence 1,1,1,2; `resume` → state 0 and the held D instruction retires (`retire_cnt` +1).
- Deferred request: `halt_req` while lu → state stays 0 that cycle and enters 1 the next hazard-free cycle.
- Perf: with `PIPE_CTRL_PERF_EN` defined, 10 RUN cycles, 4 valid retirements → `cycle_cnt_o`=10, `retire_cnt_o`=4; with it undefined both read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble strobes plus RUN/DRAIN/PAUSED/HALTED run-state.
// Define PIPE_CTRL_PERF_EN to build the cycle and retired-instruction counters.
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_dstM_i,
    input  logic        e_Cnd_i,
    input  logic [3:0]  M_icode_i,
    input  logic [2:0]  m_stat_i,
    input  logic [3:0]  W_icode_i,
    input  logic [2:0]  W_stat_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_bubble_o,
    output logic        M_bubble_o,
    output logic        W_stall_o,
    output logic [1:0]  state_o,
    output logic [2:0]  halt_stat_o,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] retire_cnt_o
);
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SINS    = 3'd3;
    localparam logic [2:0] SHLT    = 3'd4;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PAUSED = 2'd2, HALTED = 2'd3} state_t;

    state_t     state_q;
    logic [2:0] halt_stat_q;
    logic       lu, rt, mp, exc_m, exc_w;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == SADR) || (s == SINS) || (s == SHLT);
    endfunction

    assign lu    = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE) &&
                   ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign rt    = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign mp    = (E_icode_i == IJXX) && !e_Cnd_i;
    assign exc_m = is_exc(m_stat_i);
    assign exc_w = is_exc(W_stat_i);

    // Outside RUN, F/D are frozen so the instruction held in D survives the pause intact.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = exc_m | exc_w;
        W_stall_o  = exc_w;
        case (state_q)
            RUN: begin
                F_stall_o  = lu | rt;
                D_stall_o  = lu;
                D_bubble_o = mp | (rt & ~lu);
                E_bubble_o = mp | lu;
            end
            DRAIN: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
            end
            default: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
                M_bubble_o = 1'b1;
                W_stall_o  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            halt_stat_q <= SAOK;
        end else if (state_q != HALTED && exc_w) begin
            state_q     <= HALTED;
            halt_stat_q <= W_stat_i;
        end else begin
            case (state_q)
                RUN:     if (halt_req_i && !lu && !rt && !mp) state_q <= DRAIN;
                DRAIN:   if (E_icode_i == INOP && M_icode_i == INOP && W_icode_i == INOP)
                             state_q <= PAUSED;
                PAUSED:  if (resume_i) state_q <= RUN;
                default: state_q <= state_q;
            endcase
        end
    end

    assign state_o     = state_q;
    assign halt_stat_o = halt_stat_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] cycle_cnt_q, retire_cnt_q;
    logic        active;

    assign active = (state_q == RUN) || (state_q == DRAIN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (active) cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (active && W_icode_i != INOP && W_stat_i == SAOK)
                retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
`else
    assign cycle_cnt_o  = '0;
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl against a spec-level reference model.
module tb_pipe_ctrl;
    localparam logic [2:0] SAOK = 3'd1, SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4;
    localparam logic [3:0] INOP = 4'h1, IOPQ = 4'h6, IMRMOVQ = 4'h5, IJXX = 4'h7,
                           IRET = 4'h9, IPOPQ = 4'hB, RNONE = 4'hF;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic [3:0]  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i, W_icode_i;
    logic        e_Cnd_i, halt_req_i, resume_i;
    logic [2:0]  m_stat_i, W_stat_i;
    logic        F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o;
    logic [1:0]  state_o;
    logic [2:0]  halt_stat_o;
    logic [63:0] cycle_cnt_o, retire_cnt_o;

    pipe_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
        .M_icode_i(M_icode_i), .m_stat_i(m_stat_i),
        .W_icode_i(W_icode_i), .W_stat_i(W_stat_i),
        .halt_req_i(halt_req_i), .resume_i(resume_i),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
        .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o), .W_stall_o(W_stall_o),
        .state_o(state_o), .halt_stat_o(halt_stat_o),
        .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0, n_fail = 0;

    // Reference model: state as 0..3, counters as plain integers.
    int          m_state;
    logic [2:0]  m_hstat;
    longint unsigned m_cyc, m_ret;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exc(input logic [2:0] s);
        return s == SADR || s == SINS || s == SHLT;
    endfunction
    function automatic bit f_lu();
        return (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && E_dstM_i != RNONE &&
               (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    endfunction
    function automatic bit f_rt();
        return D_icode_i == IRET || E_icode_i == IRET || M_icode_i == IRET;
    endfunction
    function automatic bit f_mp();
        return E_icode_i == IJXX && !e_Cnd_i;
    endfunction

    task automatic idle();
        D_icode_i = INOP; d_srcA_i = RNONE; d_srcB_i = RNONE;
        E_icode_i = INOP; E_dstM_i = RNONE; e_Cnd_i = 1'b1; M_icode_i = INOP;
        m_stat_i = SAOK; W_icode_i = INOP; W_stat_i = SAOK;
        halt_req_i = 1'b0; resume_i = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        bit lu, rt, mp, fs, ds, db, eb, mb, ws;
        lu = f_lu(); rt = f_rt(); mp = f_mp();
        mb = exc(m_stat_i) || exc(W_stat_i);
        ws = exc(W_stat_i);
        db = 0;
        if (m_state == 0) begin
            fs = lu || rt; ds = lu; db = mp || (rt && !lu); eb = mp || lu;
        end else begin
            fs = 1; ds = 1; eb = 1;
            if (m_state >= 2) begin mb = 1; ws = 1; end
        end
        chk({tag, ".strobes"}, {F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o},
            {fs, ds, db, eb, mb, ws});
        chk({tag, ".state"}, state_o, m_state[1:0]);
        chk({tag, ".hstat"}, halt_stat_o, m_hstat);
        chk({tag, ".cyc"}, cycle_cnt_o, m_cyc);
        chk({tag, ".ret"}, retire_cnt_o, m_ret);
    endtask

    // Called at a negedge with inputs applied: check, clock once, advance model.
    task automatic step(input string tag);
        bit lu, rt, mp;
        #1;
        check_outputs(tag);
        lu = f_lu(); rt = f_rt(); mp = f_mp();
        @(posedge clk_i);
`ifdef PIPE_CTRL_PERF_EN
        if (m_state <= 1) m_cyc++;
        if (m_state <= 1 && W_icode_i != INOP && W_stat_i == SAOK) m_ret++;
`endif
        if (m_state != 3 && exc(W_stat_i)) begin
            m_state = 3; m_hstat = W_stat_i;
        end else if (m_state == 0 && halt_req_i && !lu && !rt && !mp) m_state = 1;
        else if (m_state == 1 && E_icode_i == INOP && M_icode_i == INOP && W_icode_i == INOP) m_state = 2;
        else if (m_state == 2 && resume_i) m_state = 0;
        @(negedge clk_i);
    endtask

    // Asynchronous reset asserted at a negedge; outputs must clear before any clock edge.
    task automatic do_reset();
        idle();
        rst_n_i = 1'b0;
        m_state = 0; m_hstat = SAOK; m_cyc = 0; m_ret = 0;
        #1;
        check_outputs("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 7))
            0, 1, 2: return INOP;
            3:       return IMRMOVQ;
            4:       return IPOPQ;
            5:       return IJXX;
            6:       return ($urandom_range(0, 2) == 0) ? IRET : IOPQ;
            default: return IOPQ;
        endcase
    endfunction

    task automatic randomize_inputs();
        D_icode_i = rnd_icode();
        d_srcA_i  = 4'($urandom_range(0, 3));
        d_srcB_i  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : RNONE;
        E_icode_i = rnd_icode();
        E_dstM_i  = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
        e_Cnd_i   = 1'($urandom_range(0, 1));
        M_icode_i = rnd_icode();
        W_icode_i = rnd_icode();
        m_stat_i  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
        W_stat_i  = ($urandom_range(0, 119) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
        if (m_state == 1 && $urandom_range(0, 3) != 0) begin
            E_icode_i = INOP; M_icode_i = INOP; W_icode_i = INOP;
        end
        if ($urandom_range(0, 5) == 0) halt_req_i = ~halt_req_i;
        resume_i  = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        int halted_for;
        idle();
        @(negedge clk_i);
        do_reset();
        step("idle");

        // Load/use
        E_icode_i = IMRMOVQ; E_dstM_i = 4'd3; d_srcA_i = 4'd3;
        #1;
        chk("lu.F_stall", F_stall_o, 1); chk("lu.D_bubble", D_bubble_o, 0);
        step("lu");
        idle();

        // Mispredict with ret in D
        E_icode_i = IJXX; e_Cnd_i = 1'b0; D_icode_i = IRET;
        #1;
        chk("mpret.DE", {D_bubble_o, E_bubble_o, F_stall_o}, 3'b111);
        step("mpret");
        idle();

        // Deferred halt request: lu present, then clears
        halt_req_i = 1'b1; E_icode_i = IPOPQ; E_dstM_i = 4'd2; d_srcB_i = 4'd2;
        step("defer0");
        chk("defer.state0", state_o, 2'd0);
        E_icode_i = IOPQ; W_icode_i = IOPQ;
        step("defer1");
        chk("defer.state1", state_o, 2'd1);
        halt_req_i = 1'b0; D_icode_i = IOPQ;
        E_icode_i = IOPQ; M_icode_i = IOPQ; W_icode_i = IOPQ;
        step("drain1");
        E_icode_i = INOP;
        step("drain2");
        M_icode_i = INOP;
        step("drain3");
        W_icode_i = INOP;
        step("drain4");
        chk("drain.paused", state_o, 2'd2);
        resume_i = 1'b1;
        step("resume");
        resume_i = 1'b0;
        chk("resume.run", state_o, 2'd0);
        W_icode_i = IOPQ;
        step("retire_held");
        idle();

        // Exception freeze
        W_stat_i = SADR; W_icode_i = IMRMOVQ;
        #1;
        chk("exc.WM", {W_stall_o, M_bubble_o}, 2'b11);
        step("exc");
        chk("exc.halted", state_o, 2'd3);
        chk("exc.hstat", halt_stat_o, SADR);
        idle(); resume_i = 1'b1; halt_req_i = 1'b1;
        step("halted_resume");
        chk("halted.sticky", state_o, 2'd3);
        do_reset();

        // Randomized run
        halted_for = 0;
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step("rnd");
            halted_for = (m_state == 3) ? halted_for + 1 : 0;
            if (halted_for > 4 || (m_state == 1 && $urandom_range(0, 29) == 0)) begin
                do_reset();
                halted_for = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
